// File: rtl/nv_pdp_dma_pkg.sv
// Shared definitions for the PDP read DMA request/response payloads.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nv_pdp_dma_pkg;

  localparam int RD_REQ_W   = 79;
  localparam int RD_RSP_W   = 257;
  localparam int ATOM_BYTES = 32;

  // Field offsets inside the request / response payloads.
  localparam int ADDR_LSB = 0;
  localparam int ADDR_MSB = 63;
  localparam int SIZE_LSB = 64;
  localparam int SIZE_MSB = 78;
  localparam int MASK_BIT = 256;

  localparam int SIZE_W = SIZE_MSB - SIZE_LSB + 1;

  // Request payload: the size field sits above the byte address.
  typedef struct packed {
    logic [SIZE_W-1:0]        size;  // beats - 1
    logic [ADDR_MSB:ADDR_LSB] addr;  // byte address
  } rd_req_pd_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } rd_state_e;

endpackage

// File: rtl/nv_pdp_rsp_fifo.sv
// Response buffer: synchronous FIFO whose head is driven from flops, with an occupancy count.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: none internally; the producer must not push when full unless it also pops.
//
// Ports: clk/rst_n (async active-low), push/push_dat, pop, head (current entry),
//        empty, count (occupancy before this cycle's push/pop).
module nv_pdp_rsp_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign head  = mem_q[rd_ptr];

  // Storage needs no reset; empty masks whatever it holds.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The producer's credit scheme makes overflow impossible; catch it if that ever breaks.
  assert property (@(posedge clk) disable iff (!rst_n) push |-> (!full || pop));

endmodule

// File: rtl/nv_pdp_mcif_rd_responder.sv
// Memory-side responder for PDP read DMA: turns bursts into per-atom SRAM reads and buffered beats.
// Latency: request accept edge E0 -> mem read in cycle 1 -> response valid in cycle 3.
// Backpressure: reads are credit-limited by FIFO space, so a stalled response port stalls issue.
//
// Ports: nvdla_core_clk / nvdla_core_rstn (async active-low);
//        rd_req_valid/rd_req_ready/rd_req_pd  request in ({size, byte addr});
//        rd_rsp_valid/rd_rsp_ready/rd_rsp_pd  response out ({mask=1, data});
//        mem_rd_en/mem_rd_addr/mem_rd_data    synchronous backing read (data one cycle later);
//        busy                                 any work outstanding.
module nv_pdp_mcif_rd_responder
  import nv_pdp_dma_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 256
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rstn,
  input  logic                rd_req_valid,
  output logic                rd_req_ready,
  input  logic [RD_REQ_W-1:0] rd_req_pd,
  output logic                rd_rsp_valid,
  input  logic                rd_rsp_ready,
  output logic [RD_RSP_W-1:0] rd_rsp_pd,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_rd_addr,
  input  logic [DATA_W-1:0]   mem_rd_data,
  output logic                busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  rd_req_pd_t        req;
  rd_state_e         state;
  logic [ADDR_W-1:0] ptr;
  logic [SIZE_W-1:0] remaining;
  logic              inflight;

  logic              issue;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              rsp_pop;
  logic [CNT_W:0]    credits_used;
  logic              unused_addr_bits;

  assign req = rd_req_pd;

  // Sub-atom offset and address bits beyond the backing capacity are dropped silently.
  assign unused_addr_bits = ^{req.addr[4:0], req.addr[ADDR_MSB:ADDR_W+5]};

  assign rd_req_ready = (state == ST_IDLE);

  // Credits: entries already buffered plus the read whose data lands next edge.
  // Count is sampled before this cycle's pop, which costs one entry of slack
  // but keeps the issue decision off the response-ready path.
  assign credits_used = {1'b0, fifo_cnt} + (CNT_W + 1)'(inflight);
  assign issue        = (state == ST_BURST) && (credits_used < (CNT_W + 1)'(FIFO_DEPTH));

  assign mem_rd_en   = issue;
  assign mem_rd_addr = ptr;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      case (state)
        ST_IDLE: begin
          if (rd_req_valid) begin
            ptr       <= req.addr[ADDR_W+4:5];
            remaining <= req.size;
            state     <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (issue) begin
            ptr       <= ptr + ADDR_W'(1);  // wraps at the top of the backing memory
            remaining <= remaining - SIZE_W'(1);
            if (remaining == '0) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_pop = rd_rsp_valid && rd_rsp_ready;

  nv_pdp_rsp_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_rsp_fifo (
    .clk      (nvdla_core_clk),
    .rst_n    (nvdla_core_rstn),
    .push     (inflight),
    .push_dat (mem_rd_data),
    .pop      (rsp_pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  assign rd_rsp_valid = !fifo_empty;
  assign rd_rsp_pd    = {1'b1, fifo_head};

  assign busy = (state == ST_BURST) | inflight | !fifo_empty;

endmodule

// File: tb/tb_nv_pdp_mcif_rd_responder.sv
// Bench for nv_pdp_mcif_rd_responder: scoreboard on the response port plus directed timing checks.
// Latency: n/a.
// Backpressure: response ready driven fixed or random per test.
module tb_nv_pdp_mcif_rd_responder;

  logic         clk;
  logic         rst_n;
  logic         rd_req_valid;
  logic         rd_req_ready;
  logic [78:0]  rd_req_pd;
  logic         rd_rsp_valid;
  logic         rd_rsp_ready;
  logic [256:0] rd_rsp_pd;
  logic         mem_rd_en;
  logic [15:0]  mem_rd_addr;
  logic [255:0] mem_rd_data;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;
  int beat_cnt = 0;
  int iss_cnt = 0;
  logic rdy_fixed = 1'b1;
  logic rand_rdy = 1'b0;
  logic [256:0] exp_q[$];

  nv_pdp_mcif_rd_responder #(
    .ADDR_W     (16),
    .FIFO_DEPTH (4),
    .DATA_W     (256)
  ) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rst_n),
    .rd_req_valid    (rd_req_valid),
    .rd_req_ready    (rd_req_ready),
    .rd_req_pd       (rd_req_pd),
    .rd_rsp_valid    (rd_rsp_valid),
    .rd_rsp_ready    (rd_rsp_ready),
    .rd_rsp_pd       (rd_rsp_pd),
    .mem_rd_en       (mem_rd_en),
    .mem_rd_addr     (mem_rd_addr),
    .mem_rd_data     (mem_rd_data),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory content is a fixed pattern of the atom index.
  function automatic logic [255:0] pat(input logic [15:0] a);
    return {8{~a, a}};
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= pat(mem_rd_addr);
  end

  // Single driver for response ready.
  initial begin
    rd_rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rd_rsp_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_pd(input string name, input logic [256:0] act, input logic [256:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor / scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd_en) iss_cnt++;
      if (rd_rsp_valid && rd_rsp_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got %h expected none", rd_rsp_pd);
        end else begin
          chk_pd("rsp_beat", rd_rsp_pd, exp_q.pop_front());
        end
      end
    end
  end

  // Pushes the expected beats, then holds valid until accepted; returns at accept edge + #1.
  task automatic send_req(input logic [63:0] addr, input logic [14:0] size);
    logic [15:0] a0;
    bit done;
    a0 = addr[20:5];
    for (int i = 0; i <= int'(size); i++) exp_q.push_back({1'b1, pat(a0 + 16'(i))});
    rd_req_pd    = {size, addr};
    rd_req_valid = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (rd_req_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    rd_req_valid = 1'b0;
    if (!done) chk("req_accept_timeout", 0, 1);
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    chk({name, "_drained"}, 64'(done), 1);
    chk({name, "_q_empty"}, 64'(exp_q.size()), 0);
  endtask

  initial begin
    logic [256:0] head0;
    int b0;
    bit hit;

    rst_n        = 1'b0;
    rd_req_valid = 1'b0;
    rd_req_pd    = '0;
    #1;
    chk("rst_req_ready", 64'(rd_req_ready), 1);
    chk("rst_rsp_valid", 64'(rd_rsp_valid), 0);
    chk("rst_mem_rd_en", 64'(mem_rd_en), 0);
    chk("rst_busy",      64'(busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beat: atom 0x10.
    send_req(64'h200, 15'd0);
    @(negedge clk);  // cycle 1
    chk("sb_c1_en",   64'(mem_rd_en), 1);
    chk("sb_c1_addr", 64'(mem_rd_addr), 64'h10);
    @(negedge clk);  // cycle 2
    chk("sb_c2_valid", 64'(rd_rsp_valid), 0);
    chk("sb_c2_busy",  64'(busy), 1);
    @(negedge clk);  // cycle 3
    chk("sb_c3_valid", 64'(rd_rsp_valid), 1);
    chk_pd("sb_c3_pd", rd_rsp_pd, {1'b1, {8{32'hFFEF0010}}});
    @(negedge clk);  // cycle 4
    chk("sb_c4_busy", 64'(busy), 0);
    drain("single");

    // Burst of 4 from atom 0: no bubbles, request ready back in cycle 5.
    @(posedge clk);
    #1;
    send_req(64'h0, 15'd3);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk($sformatf("b4_c%0d_en", c),    64'(mem_rd_en), 64'(c <= 4));
      if (c <= 4) chk($sformatf("b4_c%0d_addr", c), 64'(mem_rd_addr), 64'(c - 1));
      chk($sformatf("b4_c%0d_valid", c), 64'(rd_rsp_valid), 64'(c >= 3));
      chk($sformatf("b4_c%0d_rdy", c),   64'(rd_req_ready), 64'(c >= 5));
    end
    drain("burst4");

    // Backpressure: size 7 with ready low for 10 cycles.
    rdy_fixed = 1'b0;
    @(posedge clk);
    #2;
    iss_cnt = 0;
    b0 = beat_cnt;
    send_req(64'h2000, 15'd7);
    head0 = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 3) head0 = rd_rsp_pd;
    end
    #1;
    chk("bp_issued", 64'(iss_cnt), 4);
    chk("bp_en_stalled", 64'(mem_rd_en), 0);
    chk("bp_valid", 64'(rd_rsp_valid), 1);
    chk_pd("bp_head_stable", rd_rsp_pd, head0);
    chk_pd("bp_head_value", rd_rsp_pd, {1'b1, pat(16'h0100)});
    rdy_fixed = 1'b1;
    drain("bp");
    chk("bp_beats", 64'(beat_cnt - b0), 8);
    chk("bp_issued_total", 64'(iss_cnt), 8);

    // Wrap at the top of the backing memory.
    @(posedge clk);
    #1;
    send_req(64'hFFFFE0, 15'd1);
    @(negedge clk);
    chk("wrap_addr0", 64'(mem_rd_addr), 64'hFFFF);
    @(negedge clk);
    chk("wrap_addr1", 64'(mem_rd_addr), 64'h0000);
    drain("wrap");

    // Reset in the middle of a 16-beat burst.
    @(posedge clk);
    #1;
    b0 = beat_cnt;
    send_req(64'h1000, 15'd15);
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(posedge clk);
      #2;
      if (beat_cnt - b0 >= 5) hit = 1'b1;
    end
    chk("mr_reached_5", 64'(hit), 1);
    rst_n = 1'b0;
    #1;
    chk("mr_rsp_valid", 64'(rd_rsp_valid), 0);
    chk("mr_mem_rd_en", 64'(mem_rd_en), 0);
    chk("mr_busy",      64'(busy), 0);
    chk("mr_req_ready", 64'(rd_req_ready), 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    b0 = beat_cnt;
    repeat (10) @(negedge clk);
    chk("mr_no_stale", 64'(beat_cnt - b0), 0);
    @(posedge clk);
    #1;
    send_req(64'h60, 15'd0);
    drain("mr_fresh");
    chk("mr_fresh_beats", 64'(beat_cnt - b0), 1);

    // Back-to-back requests with random ready.
    rand_rdy = 1'b1;
    @(posedge clk);
    #2;
    b0 = beat_cnt;
    send_req(64'h400, 15'd2);
    send_req(64'h800, 15'd0);
    drain("b2b");
    chk("b2b_beats", 64'(beat_cnt - b0), 4);
    rand_rdy = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
